// File: rtl/dmem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// dmem_arbiter_pkg
// Shared types for the data-memory arbiter.
//   dmem_arb_state_t : arbiter FSM states (IDLE, ACK)
//   dmem_req_t       : one memory request bus (rd, wr, addr, wdata, func3).
//                      The same shape is used for the core, ext and mem buses.
//   DMEM_DATA_W / DMEM_ADDR_W size the request struct; the arbiter's
//   DATA_W / DM_ADDRESS parameters default to these and are expected to match.
// -----------------------------------------------------------------------------
package dmem_arbiter_pkg;

   localparam int DMEM_DATA_W = 32;
   localparam int DMEM_ADDR_W = 9;

   typedef enum logic {
      IDLE = 1'b0,
      ACK  = 1'b1
   } dmem_arb_state_t;

   typedef struct packed {
      logic                   rd;
      logic                   wr;
      logic [DMEM_ADDR_W-1:0] addr;
      logic [DMEM_DATA_W-1:0] wdata;
      logic [2:0]             func3;
   } dmem_req_t;

   // Width needed to hold 0..max_val inclusive.
   function automatic int sat_cnt_width(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/dmem_arbiter_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Up-counter that saturates at MAX. Clear has priority over increment.
// Used by dmem_arbiter to count how long the ext port has been waiting.
// Ports:
//   clk, reset   clock, synchronous active-high reset (count -> 0)
//   inc          increment by one unless already at MAX
//   clr          clear to zero
//   count        current value
// -----------------------------------------------------------------------------
module sat_counter
   import dmem_arbiter_pkg::*;
#(
   parameter int WIDTH = sat_cnt_width(8),
   parameter int MAX   = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc,
   input  logic             clr,
   output logic [WIDTH-1:0] count
);

   localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MAX);

   logic [WIDTH-1:0] count_reg;
   logic [WIDTH-1:0] count_next;

   always_comb begin
      count_next = count_reg;
      if (clr) begin
         count_next = '0;
      end else if (inc && (count_reg != MAX_VAL)) begin
         count_next = count_reg + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_reg <= '0;
      end else begin
         count_reg <= count_next;
      end
   end

   assign count = count_reg;

endmodule

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Shares the single data memory between the pipeline MEM stage (core port,
// priority) and an external loader/debug port (ext port).
//
// Build option: define DMEM_ARB_STARVE_EN to build the starvation counter.
// With it, an ext request that has waited STARVE_MAX cycles is forced in
// over a core access and the pipeline is stalled for that one cycle.
// Without it the core has strict priority and core_stall is tied low.
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   core_rd/wr/addr/wdata/func3 MEM-stage access (0-cycle pass-through)
//   core_rdata                  load data, combinational from mem_rdata
//   core_stall                  hold IF..MEM this cycle; core access dropped
//   ext_req/we/addr/wdata/func3 ext request, held until ext_ack
//   ext_ack, ext_rdata          one-cycle completion pulse + captured data
//   mem_rd/wr/addr/wdata/func3  to datamemory
//   mem_rdata                   from datamemory (combinational read)
// -----------------------------------------------------------------------------
module dmem_arbiter
   import dmem_arbiter_pkg::*;
#(
   parameter int DATA_W     = DMEM_DATA_W,
   parameter int DM_ADDRESS = DMEM_ADDR_W,
   parameter int STARVE_MAX = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   // core (MEM stage)
   input  logic                  core_rd,
   input  logic                  core_wr,
   input  logic [DM_ADDRESS-1:0] core_addr,
   input  logic [DATA_W-1:0]     core_wdata,
   input  logic [2:0]            core_func3,
   output logic [DATA_W-1:0]     core_rdata,
   output logic                  core_stall,
   // ext port
   input  logic                  ext_req,
   input  logic                  ext_we,
   input  logic [DM_ADDRESS-1:0] ext_addr,
   input  logic [DATA_W-1:0]     ext_wdata,
   input  logic [2:0]            ext_func3,
   output logic                  ext_ack,
   output logic [DATA_W-1:0]     ext_rdata,
   // datamemory
   output logic                  mem_rd,
   output logic                  mem_wr,
   output logic [DM_ADDRESS-1:0] mem_addr,
   output logic [DATA_W-1:0]     mem_wdata,
   output logic [2:0]            mem_func3,
   input  logic [DATA_W-1:0]     mem_rdata
);

   if ((STARVE_MAX < 1) || (STARVE_MAX > 255)) begin : g_bad_starve_max
      $error("dmem_arbiter: STARVE_MAX must be in 1..255");
   end

   dmem_arb_state_t state_reg;
   dmem_arb_state_t state_next;

   dmem_req_t   core_bus;
   dmem_req_t   ext_bus;
   dmem_req_t   mem_bus;

   logic        core_act;
   logic        ext_grant;
   logic        force_grant;
   logic [DATA_W-1:0] ext_rdata_reg;

   assign core_act = core_rd | core_wr;

   // Both rd and wr from the core are forwarded as-is, even if both are set.
   assign core_bus = '{rd: core_rd, wr: core_wr, addr: core_addr,
                       wdata: core_wdata, func3: core_func3};
   assign ext_bus  = '{rd: !ext_we, wr: ext_we, addr: ext_addr,
                       wdata: ext_wdata, func3: ext_func3};

`ifdef DMEM_ARB_STARVE_EN
   localparam int CNT_W = sat_cnt_width(STARVE_MAX);

   logic [CNT_W-1:0] wait_cnt;
   logic             wait_inc;
   logic             wait_clr;

   // Counts IDLE cycles in which ext is asking but loses. It holds in ACK
   // (ext cannot be granted there anyway) and restarts once ext gets in or
   // drops its request.
   assign wait_inc = (state_reg == IDLE) && ext_req && !ext_grant;
   assign wait_clr = ext_grant || !ext_req;

   sat_counter #(
      .WIDTH (CNT_W),
      .MAX   (STARVE_MAX)
   ) u_wait_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (wait_inc),
      .clr   (wait_clr),
      .count (wait_cnt)
   );

   // Only relevant when the core is active; otherwise ext wins without force.
   assign force_grant = !reset && (state_reg == IDLE) && ext_req && core_act
                        && (wait_cnt == CNT_W'(STARVE_MAX));
`else
   assign force_grant = 1'b0;
`endif

   // ---------------------------------------------------------------- state reg
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // ---------------------------------------------------------------- next state
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (ext_grant) state_next = ACK;
         ACK:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // ---------------------------------------------------------------- outputs
   always_comb begin
      ext_grant  = 1'b0;
      core_stall = 1'b0;
      ext_ack    = 1'b0;
      mem_bus    = '0;

      if (!reset) begin
         ext_ack    = (state_reg == ACK);
         ext_grant  = (state_reg == IDLE) && ext_req && (!core_act || force_grant);
         core_stall = force_grant;

         if (ext_grant) begin
            mem_bus = ext_bus;
         end else if (core_act) begin
            mem_bus = core_bus;
         end
      end
   end

   // Ext read data is captured in the grant cycle (also on writes, where the
   // value is meaningless) and held until the next grant.
   always_ff @(posedge clk) begin
      if (reset) begin
         ext_rdata_reg <= '0;
      end else if (ext_grant) begin
         ext_rdata_reg <= mem_rdata;
      end
   end

   assign ext_rdata  = ext_rdata_reg;
   assign core_rdata = mem_rdata;

   assign mem_rd    = mem_bus.rd;
   assign mem_wr    = mem_bus.wr;
   assign mem_addr  = mem_bus.addr;
   assign mem_wdata = mem_bus.wdata;
   assign mem_func3 = mem_bus.func3;

endmodule
